exec_unit: RTL and testbench
============================

Name: exec_unit

Overview:
Execute stage of the eightbit core, directly downstream of decode. Consumes one decoded instruction (type, 6-bit operand address, src/dst bit) when decode signals ready. Performs the register load/store, ALU operation or jump, then reports the next PC back to the fetch side. Owns the A/B accumulators and Z/C flags and drives the shared data-memory port.

Parameters:
DATA_BASE, 8'h00, base added to the 6-bit operand address to form the data-memory address (8-bit wrap)
JMP_PAGE, 2'b00, upper two bits of a jump target; target = {JMP_PAGE, op_addr}

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  synchronous reset, active low
en  in  1  decode-ready strobe; fields valid while high
inst_type  in  2  00 A-mem, 01 B-mem, 10 ALU, 11 JMP
op_addr  in  6  operand address / ALU op select / jump target low bits
srcdst  in  1  mem: 0 = load into reg, 1 = store from reg; JMP: 0 = unconditional, 1 = jump if Z
pc_in  in  8  PC of the instruction being executed
mem_data_in  in  8  memory read data, valid one cycle after mem_addr is presented
mem_addr  out  8  data-memory address
mem_data_out  out  8  store data
mem_we  out  1  write strobe, one cycle per store
pc_out  out  8  next PC, valid when ready=1
pc_load  out  1  high with ready when a jump is taken
ready  out  1  one-cycle completion pulse
busy  out  1  high from accept until the cycle after ready
reg_a, reg_b  out  8  architectural registers
flag_z, flag_c  out  1  zero / carry flags

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; reg_a, reg_b, flags, mem_addr, mem_data_out, pc_out = 0; mem_we, pc_load, ready, busy = 0. Reset mid-operation aborts the instruction: no register/flag update, mem_we low after that edge.
- States: IDLE, RD, WB, WR, EXEC, DONE.
- IDLE: en=1 -> latch inst_type, op_addr, srcdst, pc_in; busy=1; go RD (load), WR (store), EXEC (ALU/JMP). en while busy is ignored (no queueing); decode must not re-strobe before ready.
- RD: mem_addr = DATA_BASE + op_addr, mem_we=0 -> WB.
- WB: capture mem_data_in into A (type 00) or B (type 01); Z = (value==0); C unchanged -> DONE.
- WR: mem_addr as RD, mem_data_out = A or B, mem_we=1 for exactly this cycle -> DONE. Flags unchanged.
- EXEC ALU, op = op_addr[2:0] (op_addr[5:3] ignored): 000 A=A+B, C=carry-out; 001 A=A-B, C=borrow (A<B unsigned); 010 AND; 011 OR; 100 XOR; 101 A=~A; 110 B=A; 111 swap A/B. Logic ops 010-101 clear C; 110/111 leave C. Z from the written A (B for 110; new A for 111). All arithmetic 8-bit, wraps.
- EXEC JMP: taken if srcdst=0, or srcdst=1 and flag_z=1. pc_out = taken ? {JMP_PAGE, op_addr} : pc_in+1 (wraps FF->00); pc_load = taken.
- Non-jump instructions: pc_out = pc_in+1, pc_load=0.
- DONE: ready=1, pc_load as computed, busy stays high this cycle -> IDLE (busy=0 next cycle). New en accepted only in IDLE.
- Latency, edge sampling en to ready-high cycle: load 3, store/ALU/JMP 2. Throughput one instruction per latency+1 cycles.
- mem_we never high outside WR; mem_addr holds last value otherwise.

Optional Feature:
EXEC_RETIRE_CNT_EN: defined -> extra output retired_cnt [15:0], reset 0, increments on every ready pulse, wraps FFFF->0000. Undefined -> port and counter absent; all other behaviour identical.

Decomposition:
- Package exec_pkg: inst_type encodings, ALU op codes, state enum, DATA_W=8.
- One sub-module: exec_alu (combinational: a, b, op -> result_a, result_b, z, c, writes_b). FSM, memory sequencing and PC logic stay in exec_unit.

Test Plan:
- Load A: mem[0x05]=0x3C, en with type 00, op_addr 05, srcdst 0 -> mem_addr=0x05 on RD, reg_a=0x3C, Z=0, ready exactly 3 cycles after en.
- Store B: reg_b=0xA5, type 01, op_addr 3F, srcdst 1 -> mem_we high for one cycle, mem_addr=0x3F, mem_data_out=0xA5, ready at 2 cycles.
- ALU ADD overflow: A=0xF0, B=0x10, op 000 -> A=0x00, Z=1, C=1; then SUB A=0x00, B=0x01 -> A=0xFF, C=1, Z=0.
- Conditional jump: Z=1, type 11, srcdst 1, op_addr 0x12, pc_in 0x40 -> pc_out=0x12, pc_load=1; with Z=0 -> pc_out=0x41, pc_load=0; pc_in 0xFF non-jump -> pc_out=0x00.
- en re-asserted while busy during a load -> ignored, no second ready; reset asserted in WR state -> mem_we low after that edge, registers 0, state IDLE.
- With EXEC_RETIRE_CNT_EN: 5 back-to-back instructions -> retired_cnt=5.

Source files
------------

// File: rtl/exec_unit_pkg.sv
// exec_pkg: shared types for the eightbit execute stage.
//   - instruction type encodings (inst_type field from decode)
//   - ALU operation codes (op_addr[2:0] for ALU instructions)
//   - execute FSM state enum
//   - DATA_W: architectural data width
package exec_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IT_AMEM = 2'b00,
        IT_BMEM = 2'b01,
        IT_ALU  = 2'b10,
        IT_JMP  = 2'b11
    } inst_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_NOT = 3'b101,
        ALU_MOV = 3'b110,
        ALU_SWP = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WB,
        S_WR,
        S_EXEC,
        S_DONE
    } state_e;

endpackage

// File: rtl/exec_unit_alu.sv
// exec_alu: combinational ALU for the execute stage.
// Ports:
//   a, b      in   current A/B register values
//   op        in   ALU operation code
//   result_a  out  new A value (A unchanged unless the op writes it)
//   result_b  out  new B value (equals b unless writes_b)
//   z         out  zero flag of the written register (B for MOV, new A otherwise)
//   c         out  carry/borrow for ADD/SUB, 0 for logic ops; meaningless
//                  for MOV/SWP, where the caller keeps the old carry
//   writes_b  out  op writes B (MOV/SWP); also marks the carry-preserving ops
module exec_alu
    import exec_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] result_a,
    output logic [DATA_W-1:0] result_b,
    output logic              z,
    output logic              c,
    output logic              writes_b
);

    logic [DATA_W:0] sum;

    always_comb begin
        result_a = a;
        result_b = b;
        c        = 1'b0;
        writes_b = 1'b0;
        sum      = '0;
        case (op)
            ALU_ADD: begin
                sum      = {1'b0, a} + {1'b0, b};
                result_a = sum[DATA_W-1:0];
                c        = sum[DATA_W];
            end
            ALU_SUB: begin
                result_a = a - b;
                c        = (a < b);
            end
            ALU_AND: result_a = a & b;
            ALU_OR:  result_a = a | b;
            ALU_XOR: result_a = a ^ b;
            ALU_NOT: result_a = ~a;
            ALU_MOV: begin
                result_b = a;
                writes_b = 1'b1;
            end
            ALU_SWP: begin
                result_a = b;
                result_b = a;
                writes_b = 1'b1;
            end
            default: ;
        endcase
        z = (op == ALU_MOV) ? (result_b == '0) : (result_a == '0);
    end

endmodule

// File: rtl/exec_unit.sv
// exec_unit: execute stage of the eightbit core.
// Accepts one decoded instruction per en strobe in IDLE, performs the
// memory load/store, ALU op or jump, and reports the next PC with ready.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   en                    decode-ready strobe (ignored unless IDLE)
//   inst_type, op_addr,   decoded instruction fields
//   srcdst, pc_in
//   mem_data_in           data memory read data (one cycle after mem_addr)
//   mem_addr,             data memory address / store data / write strobe
//   mem_data_out, mem_we
//   pc_out, pc_load       next PC and jump-taken, valid with ready
//   ready, busy           completion pulse / instruction in flight
//   reg_a, reg_b          accumulators
//   flag_z, flag_c        zero / carry flags
//   retired_cnt           retired-instruction counter, present only when
//                         EXEC_RETIRE_CNT_EN is defined
module exec_unit
    import exec_pkg::*;
#(
    parameter logic [7:0] DATA_BASE = 8'h00,
    parameter logic [1:0] JMP_PAGE  = 2'b00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        inst_type,
    input  logic [5:0]        op_addr,
    input  logic              srcdst,
    input  logic [7:0]        pc_in,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic [7:0]        mem_addr,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_we,
    output logic [7:0]        pc_out,
    output logic              pc_load,
    output logic              ready,
    output logic              busy,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b,
    output logic              flag_z,
`ifdef EXEC_RETIRE_CNT_EN
    output logic              flag_c,
    output logic [15:0]       retired_cnt
`else
    output logic              flag_c
`endif
);

    state_e            state_q, state_d;
    inst_e             type_q, type_d;
    logic [5:0]        addr_q, addr_d;
    logic              sd_q, sd_d;
    logic [7:0]        pc_q, pc_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic              z_q, z_d, c_q, c_d;
    logic [7:0]        maddr_q, maddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        pc_out_q, pc_out_d;
    logic              pc_load_q, pc_load_d;
`ifdef EXEC_RETIRE_CNT_EN
    logic [15:0]       cnt_q, cnt_d;
`endif

    logic [DATA_W-1:0] alu_a, alu_b;
    logic              alu_z, alu_c, alu_wb;
    logic              taken;

    exec_alu u_alu (
        .a        (a_q),
        .b        (b_q),
        .op       (alu_op_e'(addr_q[2:0])),
        .result_a (alu_a),
        .result_b (alu_b),
        .z        (alu_z),
        .c        (alu_c),
        .writes_b (alu_wb)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            type_q    <= IT_AMEM;
            addr_q    <= '0;
            sd_q      <= 1'b0;
            pc_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            maddr_q   <= '0;
            wdata_q   <= '0;
            pc_out_q  <= '0;
            pc_load_q <= 1'b0;
`ifdef EXEC_RETIRE_CNT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            addr_q    <= addr_d;
            sd_q      <= sd_d;
            pc_q      <= pc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            z_q       <= z_d;
            c_q       <= c_d;
            maddr_q   <= maddr_d;
            wdata_q   <= wdata_d;
            pc_out_q  <= pc_out_d;
            pc_load_q <= pc_load_d;
`ifdef EXEC_RETIRE_CNT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        addr_d    = addr_q;
        sd_d      = sd_q;
        pc_d      = pc_q;
        a_d       = a_q;
        b_d       = b_q;
        z_d       = z_q;
        c_d       = c_q;
        maddr_d   = maddr_q;
        wdata_d   = wdata_q;
        pc_out_d  = pc_out_q;
        pc_load_d = pc_load_q;
        taken     = 1'b0;
`ifdef EXEC_RETIRE_CNT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    type_d = inst_e'(inst_type);
                    addr_d = op_addr;
                    sd_d   = srcdst;
                    pc_d   = pc_in;
                    if (inst_type == IT_AMEM || inst_type == IT_BMEM) begin
                        // Address (and store data) are registered on accept so
                        // they are already on the port during RD/WR.
                        maddr_d = DATA_BASE + {2'b00, op_addr};
                        if (srcdst) begin
                            wdata_d = (inst_type == IT_AMEM) ? a_q : b_q;
                            state_d = S_WR;
                        end else begin
                            state_d = S_RD;
                        end
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_RD: state_d = S_WB;
            S_WB: begin
                if (type_q == IT_AMEM) a_d = mem_data_in;
                else                   b_d = mem_data_in;
                z_d       = (mem_data_in == '0);
                pc_out_d  = pc_q + 8'd1;
                pc_load_d = 1'b0;
                state_d   = S_DONE;
            end
            S_WR: begin
                pc_out_d  = pc_q + 8'd1;
                pc_load_d = 1'b0;
                state_d   = S_DONE;
            end
            S_EXEC: begin
                if (type_q == IT_JMP) begin
                    taken     = !sd_q || z_q;
                    pc_out_d  = taken ? {JMP_PAGE, addr_q} : pc_q + 8'd1;
                    pc_load_d = taken;
                end else begin
                    a_d       = alu_a;
                    b_d       = alu_b;
                    z_d       = alu_z;
                    // MOV/SWP (the B-writing ops) keep the old carry.
                    c_d       = alu_wb ? c_q : alu_c;
                    pc_out_d  = pc_q + 8'd1;
                    pc_load_d = 1'b0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                pc_load_d = 1'b0;
`ifdef EXEC_RETIRE_CNT_EN
                cnt_d     = cnt_q + 16'd1;
`endif
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_addr     = maddr_q;
    assign mem_data_out = wdata_q;
    assign mem_we       = (state_q == S_WR);
    assign pc_out       = pc_out_q;
    assign pc_load      = pc_load_q;
    assign ready        = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);
    assign reg_a        = a_q;
    assign reg_b        = b_q;
    assign flag_z       = z_q;
    assign flag_c       = c_q;
`ifdef EXEC_RETIRE_CNT_EN
    assign retired_cnt  = cnt_q;
`endif

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit with a synchronous data memory
// model (read data registered one cycle after the address).
module tb_exec_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] inst_type;
    logic [5:0] op_addr;
    logic       srcdst;
    logic [7:0] pc_in;
    logic [7:0] mem_data_in;
    logic [7:0] mem_addr, mem_data_out, pc_out, reg_a, reg_b;
    logic       mem_we, pc_load, ready, busy, flag_z, flag_c;
`ifdef EXEC_RETIRE_CNT_EN
    logic [15:0] retired_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    exec_unit #(.DATA_BASE(8'h00), .JMP_PAGE(2'b00)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .inst_type    (inst_type),
        .op_addr      (op_addr),
        .srcdst       (srcdst),
        .pc_in        (pc_in),
        .mem_data_in  (mem_data_in),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .mem_we       (mem_we),
        .pc_out       (pc_out),
        .pc_load      (pc_load),
        .ready        (ready),
        .busy         (busy),
        .reg_a        (reg_a),
        .reg_b        (reg_b),
        .flag_z       (flag_z),
`ifdef EXEC_RETIRE_CNT_EN
        .retired_cnt  (retired_cnt),
`endif
        .flag_c       (flag_c)
    );

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_data_out;
        mem_data_in <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Results of the last run_inst call.
    int         lat, we_cnt;
    logic [7:0] rd_addr, we_addr, we_data, o_pc;
    logic       o_load;

    // Issue one instruction, follow it to ready (bounded), return to IDLE.
    task automatic run_inst(input logic [1:0] t, input logic [5:0] a,
                            input logic sd, input logic [7:0] pc);
        en = 1'b1; inst_type = t; op_addr = a; srcdst = sd; pc_in = pc;
        @(posedge clk); #1;
        en = 1'b0;
        lat = 0; we_cnt = 0; rd_addr = 'x; we_addr = 'x; we_data = 'x;
        o_pc = 'x; o_load = 'x;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) rd_addr = mem_addr;
            if (mem_we) begin
                we_cnt++; we_addr = mem_addr; we_data = mem_data_out;
            end
            if (ready) begin
                o_pc = pc_out; o_load = pc_load;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    int rdy_n, we_n;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h05] = 8'h3C; mem[8'h06] = 8'hA5; mem[8'h07] = 8'hF0;
        mem[8'h08] = 8'h10; mem[8'h09] = 8'h01; mem[8'h0A] = 8'h00;
        rst_n = 1'b0; en = 1'b0; inst_type = 2'b00; op_addr = '0;
        srcdst = 1'b0; pc_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_reg_a", reg_a, 8'h00);
        chk("rst_reg_b", reg_b, 8'h00);
        chk("rst_flags", {flag_z, flag_c}, 2'b00);
        chk("rst_mem_addr", mem_addr, 8'h00);
        chk("rst_mem_data_out", mem_data_out, 8'h00);
        chk("rst_pc_out", pc_out, 8'h00);
        chk("rst_ctrl", {mem_we, pc_load, ready, busy}, 4'b0000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Load A from 0x05
        run_inst(2'b00, 6'h05, 1'b0, 8'h10);
        chk("ldA_latency", lat, 3);
        chk("ldA_rd_addr", rd_addr, 8'h05);
        chk("ldA_reg_a", reg_a, 8'h3C);
        chk("ldA_z", flag_z, 1'b0);
        chk("ldA_pc", {o_load, o_pc}, {1'b0, 8'h11});
        chk("ldA_busy_after", busy, 1'b0);

        // Load B from 0x06, then store B to 0x3F
        run_inst(2'b01, 6'h06, 1'b0, 8'h11);
        chk("ldB_reg_b", reg_b, 8'hA5);
        run_inst(2'b01, 6'h3F, 1'b1, 8'h12);
        chk("stB_latency", lat, 2);
        chk("stB_we_cnt", we_cnt, 1);
        chk("stB_addr", we_addr, 8'h3F);
        chk("stB_data", we_data, 8'hA5);
        chk("stB_mem", mem[8'h3F], 8'hA5);
        chk("stB_we_after", mem_we, 1'b0);

        // ADD overflow, op field upper bits set and ignored
        run_inst(2'b00, 6'h07, 1'b0, 8'h20);
        run_inst(2'b01, 6'h08, 1'b0, 8'h21);
        run_inst(2'b10, 6'h38, 1'b0, 8'h22);
        chk("add_latency", lat, 2);
        chk("add_reg_a", reg_a, 8'h00);
        chk("add_zc", {flag_z, flag_c}, 2'b11);
        run_inst(2'b01, 6'h09, 1'b0, 8'h23);
        chk("ldB_keeps_c", {flag_z, flag_c}, 2'b01);
        run_inst(2'b10, 6'h04, 1'b0, 8'h24);
        chk("xor_reg_a", reg_a, 8'h01);
        chk("xor_zc", {flag_z, flag_c}, 2'b00);
        run_inst(2'b00, 6'h0A, 1'b0, 8'h25);
        run_inst(2'b10, 6'h01, 1'b0, 8'h26);
        chk("sub_reg_a", reg_a, 8'hFF);
        chk("sub_zc", {flag_z, flag_c}, 2'b01);

        // Conditional jump, Z=1 then Z=0; unconditional jump
        run_inst(2'b00, 6'h0A, 1'b0, 8'h30);
        run_inst(2'b11, 6'h12, 1'b1, 8'h40);
        chk("jz_taken_latency", lat, 2);
        chk("jz_taken", {o_load, o_pc}, {1'b1, 8'h12});
        chk("pc_load_after", pc_load, 1'b0);
        run_inst(2'b00, 6'h05, 1'b0, 8'h31);
        run_inst(2'b11, 6'h12, 1'b1, 8'h40);
        chk("jz_not_taken", {o_load, o_pc}, {1'b0, 8'h41});
        run_inst(2'b11, 6'h3F, 1'b0, 8'h80);
        chk("jmp_uncond", {o_load, o_pc}, {1'b1, 8'h3F});

        // NOT at pc 0xFF: next pc wraps
        run_inst(2'b10, 6'h05, 1'b0, 8'hFF);
        chk("not_pc_wrap", {o_load, o_pc}, {1'b0, 8'h00});
        chk("not_reg_a", reg_a, 8'hC3);
        chk("not_zc", {flag_z, flag_c}, 2'b00);
        // MOV, SWAP, AND, OR
        run_inst(2'b10, 6'h06, 1'b0, 8'h50);
        chk("mov_regs", {reg_a, reg_b}, 16'hC3C3);
        run_inst(2'b01, 6'h0A, 1'b0, 8'h51);
        run_inst(2'b10, 6'h07, 1'b0, 8'h52);
        chk("swp_regs", {reg_a, reg_b}, 16'h00C3);
        chk("swp_z", flag_z, 1'b1);
        run_inst(2'b10, 6'h02, 1'b0, 8'h53);
        chk("and_reg_a", {reg_a, 6'b0, flag_z, flag_c}, 16'h0002);
        run_inst(2'b10, 6'h03, 1'b0, 8'h54);
        chk("or_reg_a", {reg_a, 6'b0, flag_z, flag_c}, 16'hC300);

        // en re-strobed while a load is busy must be ignored
        rdy_n = 0; we_n = 0;
        en = 1'b1; inst_type = 2'b00; op_addr = 6'h06; srcdst = 1'b0; pc_in = 8'h60;
        @(posedge clk); #1;
        inst_type = 2'b00; op_addr = 6'h3E; srcdst = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (ready) rdy_n++;
            if (mem_we) we_n++;
            if (i == 2) en = 1'b0;
        end
        chk("busy_ign_ready_cnt", rdy_n, 1);
        chk("busy_ign_we_cnt", we_n, 0);
        chk("busy_ign_reg_a", reg_a, 8'hA5);
        chk("busy_ign_idle", busy, 1'b0);

        // Reset while in WR
        en = 1'b1; inst_type = 2'b00; op_addr = 6'h3E; srcdst = 1'b1; pc_in = 8'h70;
        @(posedge clk); #1;
        en = 1'b0;
        @(negedge clk);
        chk("wr_we_before_rst", mem_we, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_wr_ctrl", {mem_we, ready, busy, pc_load}, 4'b0000);
        chk("rst_wr_regs", {reg_a, reg_b}, 16'h0000);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_inst(2'b00, 6'h05, 1'b0, 8'h00);
        chk("post_rst_load", {lat[7:0], reg_a}, {8'd3, 8'h3C});

`ifdef EXEC_RETIRE_CNT_EN
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("retire_rst", retired_cnt, 16'd0);
        run_inst(2'b00, 6'h05, 1'b0, 8'h00);
        run_inst(2'b01, 6'h06, 1'b0, 8'h01);
        run_inst(2'b10, 6'h00, 1'b0, 8'h02);
        run_inst(2'b00, 6'h10, 1'b1, 8'h03);
        run_inst(2'b11, 6'h00, 1'b0, 8'h04);
        chk("retire_cnt5", retired_cnt, 16'd5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
